// File: rtl/bp_resolve_queue_pkg.sv
// Shared definitions for the branch-resolve queue: entry layout width and
// mispredict classification.
package bp_resolve_queue_pkg;

   localparam int unsigned ALIAS_W = 6;
   // Entry layout, MSB first: {pred, btb_hit, alias[ALIAS_W], eip[32]}
   localparam int unsigned ENTRY_W = 2 + ALIAS_W + 32;

   typedef enum logic [1:0] {
      MP_NONE = 2'd0,
      MP_DIR  = 2'd1,
      MP_BTB  = 2'd2
   } mp_reason_e;

   function automatic mp_reason_e mp_reason(input logic pred, input logic btb_hit,
                                             input logic taken);
      if (pred != taken) return MP_DIR;
      if (taken && !btb_hit) return MP_BTB;
      return MP_NONE;
   endfunction

endpackage

// File: rtl/bp_resolve_queue_if.sv
// Fetch-enqueue, writeback-resolve and predictor/BTB update bundle of the
// branch-resolve queue.
interface bp_resolve_queue_if #(
   parameter int unsigned ALIAS_W = bp_resolve_queue_pkg::ALIAS_W,
   parameter int unsigned PTR_W   = 3
);
   logic               enq_valid;
   logic               enq_pred;
   logic               enq_btb_hit;
   logic [ALIAS_W-1:0] enq_alias;
   logic [31:0]        enq_eip;
   logic               enq_ready;
   logic               res_valid;
   logic               res_taken;
   logic [31:0]        res_eip;
   logic [31:0]        res_fip_e;
   logic [31:0]        res_fip_o;
   logic               ext_flush;
   logic               upd_valid;
   logic               upd_taken;
   logic [ALIAS_W-1:0] upd_alias;
   logic [31:0]        upd_br_eip;
   logic [31:0]        upd_tgt_eip;
   logic [31:0]        upd_fip_e;
   logic [31:0]        upd_fip_o;
   logic               mispredict;
   logic [PTR_W:0]     count;
   logic               underflow_err;

   modport master (
      output enq_valid, enq_pred, enq_btb_hit, enq_alias, enq_eip,
      output res_valid, res_taken, res_eip, res_fip_e, res_fip_o, ext_flush,
      input  enq_ready, upd_valid, upd_taken, upd_alias, upd_br_eip, upd_tgt_eip,
      input  upd_fip_e, upd_fip_o, mispredict, count, underflow_err
   );

   modport slave (
      input  enq_valid, enq_pred, enq_btb_hit, enq_alias, enq_eip,
      input  res_valid, res_taken, res_eip, res_fip_e, res_fip_o, ext_flush,
      output enq_ready, upd_valid, upd_taken, upd_alias, upd_br_eip, upd_tgt_eip,
      output upd_fip_e, upd_fip_o, mispredict, count, underflow_err
   );
endinterface

// File: rtl/bp_rq_storage.sv
// DEPTH x WIDTH entry register file: one synchronous write port, one
// asynchronous read port at the queue head.
module bp_rq_storage
   import bp_resolve_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned PTR_W = 3,
   parameter int unsigned WIDTH = ENTRY_W
) (
   input  logic             clk,
   input  logic             we,
   input  logic [PTR_W-1:0] waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [PTR_W-1:0] raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/bp_resolve_queue.sv
// In-order queue of in-flight branch predictions; resolving the head issues a
// one-cycle registered predictor/BTB update and flushes on mispredict.
module bp_resolve_queue
   import bp_resolve_queue_pkg::*;
#(
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned ALIAS_W = bp_resolve_queue_pkg::ALIAS_W,
   parameter int unsigned PTR_W   = 3
) (
   input logic               clk,
   input logic               reset,
   bp_resolve_queue_if.slave bus
);

   localparam int unsigned EW = 2 + ALIAS_W + 32;

   logic [PTR_W-1:0]   head, tail;
   logic [PTR_W:0]     cnt;
   logic [EW-1:0]      wr_entry, hd_entry;
   logic               hd_pred, hd_btb;
   logic [ALIAS_W-1:0] hd_alias;
   logic [31:0]        hd_eip;
   logic               full, empty, pop, push, mp, flush;
   mp_reason_e         reason;

   assign wr_entry = {bus.enq_pred, bus.enq_btb_hit, bus.enq_alias, bus.enq_eip};
   assign {hd_pred, hd_btb, hd_alias, hd_eip} = hd_entry;

   assign full  = (cnt == (PTR_W+1)'(DEPTH));
   assign empty = (cnt == '0);
   assign pop   = bus.res_valid && !empty;

   always_comb begin
      reason = mp_reason(hd_pred, hd_btb, bus.res_taken);
   end

   assign mp    = pop && (reason != MP_NONE);
   assign flush = mp || bus.ext_flush;
   // A pop in the same cycle frees the slot, so a full queue still accepts;
   // anything arriving alongside a flush is wrong-path and is dropped.
   assign push  = bus.enq_valid && (!full || pop) && !flush;

   bp_rq_storage #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W),
      .WIDTH (EW)
   ) u_storage (
      .clk   (clk),
      .we    (push),
      .waddr (tail),
      .wdata (wr_entry),
      .raddr (head),
      .rdata (hd_entry)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head              <= '0;
         tail              <= '0;
         cnt               <= '0;
         bus.upd_valid     <= 1'b0;
         bus.upd_taken     <= 1'b0;
         bus.upd_alias     <= '0;
         bus.upd_br_eip    <= '0;
         bus.upd_tgt_eip   <= '0;
         bus.upd_fip_e     <= '0;
         bus.upd_fip_o     <= '0;
         bus.mispredict    <= 1'b0;
         bus.underflow_err <= 1'b0;
      end else begin
         if (flush) begin
            head <= tail;
            cnt  <= '0;
         end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            case ({push, pop})
               2'b10:   cnt <= cnt + (PTR_W+1)'(1);
               2'b01:   cnt <= cnt - (PTR_W+1)'(1);
               default: cnt <= cnt;
            endcase
         end

         bus.upd_valid  <= pop;
         bus.mispredict <= mp;
         if (pop) begin
            bus.upd_taken   <= bus.res_taken;
            bus.upd_alias   <= hd_alias;
            bus.upd_br_eip  <= hd_eip;
            bus.upd_tgt_eip <= bus.res_eip;
            bus.upd_fip_e   <= bus.res_fip_e;
            bus.upd_fip_o   <= bus.res_fip_o;
         end
         if (bus.res_valid && empty) bus.underflow_err <= 1'b1;
      end
   end

   assign bus.enq_ready = !full;
   assign bus.count     = cnt;

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Directed and random checks of bp_resolve_queue against a queue-based
// reference model of in-flight predictions.
module tb_bp_resolve_queue;

   localparam int DEPTH = 8;

   typedef struct {
      logic        pred;
      logic        btb;
      logic [5:0]  al;
      logic [31:0] eip;
   } ent_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   bp_resolve_queue_if #(.ALIAS_W(6), .PTR_W(3)) bus();

   bp_resolve_queue #(.DEPTH(8), .ALIAS_W(6), .PTR_W(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   ent_t        q[$];
   logic        e_uv = 1'b0, e_mp = 1'b0, e_uerr = 1'b0, e_tk = 1'b0;
   logic [5:0]  e_al = '0;
   logic [31:0] e_br = '0, e_tgt = '0, e_fe = '0, e_fo = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      chk("count",         32'(bus.count),         32'(q.size()));
      chk("enq_ready",     32'(bus.enq_ready),     32'(q.size() < DEPTH));
      chk("upd_valid",     32'(bus.upd_valid),     32'(e_uv));
      chk("mispredict",    32'(bus.mispredict),    32'(e_mp));
      chk("underflow_err", 32'(bus.underflow_err), 32'(e_uerr));
      if (e_uv) begin
         chk("upd_taken",   32'(bus.upd_taken), 32'(e_tk));
         chk("upd_alias",   32'(bus.upd_alias), 32'(e_al));
         chk("upd_br_eip",  bus.upd_br_eip,     e_br);
         chk("upd_tgt_eip", bus.upd_tgt_eip,    e_tgt);
         chk("upd_fip_e",   bus.upd_fip_e,      e_fe);
         chk("upd_fip_o",   bus.upd_fip_o,      e_fo);
      end
   endtask

   task automatic model_reset();
      q.delete();
      e_uv = 1'b0; e_mp = 1'b0; e_uerr = 1'b0;
   endtask

   // One clock: drive inputs, let the edge happen, advance the model, check.
   task automatic step(input logic ev, input logic ep, input logic eb, input logic [5:0] ea,
                       input logic [31:0] ee, input logic rv, input logic rt,
                       input logic [31:0] re, input logic [31:0] fe, input logic [31:0] fo,
                       input logic fl);
      bit   pop, mp, acc, was_full;
      ent_t h, n;
      bus.enq_valid = ev; bus.enq_pred = ep; bus.enq_btb_hit = eb;
      bus.enq_alias = ea; bus.enq_eip = ee;
      bus.res_valid = rv; bus.res_taken = rt; bus.res_eip = re;
      bus.res_fip_e = fe; bus.res_fip_o = fo; bus.ext_flush = fl;
      @(posedge clk);
      was_full = (q.size() == DEPTH);
      pop = rv && (q.size() != 0);
      mp  = 1'b0;
      if (rv && q.size() == 0) e_uerr = 1'b1;
      e_uv = pop;
      if (pop) begin
         h = q.pop_front();
         mp = (h.pred != rt) || (rt && !h.btb);
         e_tk = rt; e_al = h.al; e_br = h.eip; e_tgt = re; e_fe = fe; e_fo = fo;
      end
      e_mp = mp;
      acc = ev && (!was_full || pop) && !mp && !fl;
      if (mp || fl) q.delete();
      if (acc) begin
         n.pred = ep; n.btb = eb; n.al = ea; n.eip = ee;
         q.push_back(n);
      end
      #1;
      check_outputs();
   endtask

   task automatic enq(input logic ep, input logic eb, input logic [5:0] ea, input logic [31:0] ee);
      step(1'b1, ep, eb, ea, ee, 1'b0, 1'b0, '0, '0, '0, 1'b0);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
   endtask

   task automatic res(input logic rt);
      step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, rt, $urandom(), $urandom(), $urandom(), 1'b0);
   endtask

   initial begin
      logic p;
      bus.enq_valid = 1'b0; bus.enq_pred = 1'b0; bus.enq_btb_hit = 1'b0;
      bus.enq_alias = '0; bus.enq_eip = '0; bus.res_valid = 1'b0; bus.res_taken = 1'b0;
      bus.res_eip = '0; bus.res_fip_e = '0; bus.res_fip_o = '0; bus.ext_flush = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      check_outputs();
      @(negedge clk) reset = 1'b1;

      // Three enqueues, then fill to eight, then a dropped ninth
      enq(1'b1, 1'b1, 6'h2A, 32'h100);
      enq(1'b1, 1'b1, 6'h11, 32'h200);
      enq(1'b0, 1'b1, 6'h05, 32'h300);
      for (int i = 3; i < 8; i++) enq(1'($urandom()), 1'b1, 6'($urandom()), 32'(i * 256 + 256));
      chk("full_ready", 32'(bus.enq_ready), 32'(0));
      enq(1'b1, 1'b1, 6'h3F, 32'hDEAD);
      chk("drop_count", 32'(bus.count), 32'(8));

      // Correctly predicted taken head with alias 0x2A
      res(1'b1);
      chk("alias_2a", 32'(bus.upd_alias), 32'h2A);

      // Refill, then 16 enq+resolve pairs while full, then drain in order
      enq(1'b0, 1'b1, 6'h01, 32'h900);
      for (int i = 0; i < 16; i++)
         step(1'b1, 1'($urandom()), 1'b1, 6'($urandom()), 32'h1000 + 32'(i),
              1'b1, q[0].pred, $urandom(), $urandom(), $urandom(), 1'b0);
      for (int i = 0; i < 8; i++) res(q[0].pred);

      // Not-taken predictions, resolved taken with a same-cycle enqueue
      for (int i = 0; i < 4; i++) enq(1'b0, 1'b1, 6'(i), 32'h2000 + 32'(i));
      step(1'b1, 1'b1, 1'b1, 6'h07, 32'h3000, 1'b1, 1'b1, 32'h44, 32'h48, 32'h4C, 1'b0);
      chk("mp_pulse", 32'(bus.mispredict), 32'(1));

      // Resolve while empty
      res(1'b0);
      repeat (3) idle();

      // BTB-miss taken mispredict, then external flush together with a resolve
      enq(1'b1, 1'b0, 6'h12, 32'h5000);
      res(1'b1);
      for (int i = 0; i < 3; i++) enq(1'b0, 1'b1, 6'h20, 32'h6000 + 32'(i));
      step(1'b1, 1'b1, 1'b1, 6'h21, 32'h7000, 1'b1, 1'b0, 32'h80, 32'h84, 32'h88, 1'b1);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         p = (q.size() != 0 && $urandom_range(9) < 7) ? q[0].pred : 1'($urandom());
         step(1'($urandom_range(3) != 0), 1'($urandom()), 1'($urandom_range(4) != 0),
              6'($urandom()), $urandom(), 1'($urandom_range(2) == 0), p,
              $urandom(), $urandom(), $urandom(), 1'($urandom_range(31) == 0));
      end

      // Asynchronous reset mid-operation
      enq(1'b1, 1'b1, 6'h15, 32'h8000);
      enq(1'b0, 1'b1, 6'h16, 32'h8004);
      res(1'b1);
      res(1'b1);
      #2 reset = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(negedge clk) reset = 1'b1;
      idle();
      enq(1'b1, 1'b1, 6'h09, 32'h9000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
